mont_op_sequencer: RTL and testbench

// - Upstream issue stage for the two-pass Montgomery multiply wrapper (mont_final).
// - Accepts operand triples (A, B, P) on a valid/ready handshake and validates P.
// - Reduces A and B into [0, P) and drives the multiplier's level-sensitive start until its done.
// - Captures the product M and returns it downstream on a second valid/ready handshake with an error code.

---
 rtl/mont_op_sequencer_pkg.sv | 25 ++
 rtl/mont_op_sequencer_if.sv | 56 +++++
 rtl/mont_op_sequencer_cond_sub.sv | 23 ++
 rtl/mont_op_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mont_op_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_op_sequencer_pkg.sv
// mont_seq_pkg
// Shared types and constants for the Montgomery operand sequencer.
//   state_e : sequencer FSM states
//   err_e   : 2-bit result code returned alongside the product
//   MONT_W  : default operand/modulus width
package mont_seq_pkg;

  localparam int MONT_W = 256;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    LAUNCH,
    WAIT,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_P_EVEN  = 2'b01,
    ERR_RANGE   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

endpackage

// File: rtl/mont_op_sequencer_if.sv
// mont_op_sequencer_if
// Bundles the three handshakes of the sequencer into one interface.
//   upstream   : in_valid/in_ready with operand triple in_a, in_b, in_p
//   multiplier : mont_start/mont_done level handshake, mont_a/b/p out, mont_m in
//   downstream : out_valid/out_ready with out_m and out_err
//   status     : busy
// Modports:
//   slave  : the sequencer's view
//   master : the environment's view (operand source, multiplier, result sink)
interface mont_op_sequencer_if
  import mont_seq_pkg::*;
#(
  parameter int WIDTH = MONT_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_p;

  logic             mont_start;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic [WIDTH-1:0] mont_p;
  logic [WIDTH-1:0] mont_m;
  logic             mont_done;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_m;
  logic [1:0]       out_err;

  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_p,
    output in_ready,
    output mont_start, mont_a, mont_b, mont_p,
    input  mont_m, mont_done,
    output out_valid, out_m, out_err,
    input  out_ready,
    output busy
  );

  modport master (
    output in_valid, in_a, in_b, in_p,
    input  in_ready,
    input  mont_start, mont_a, mont_b, mont_p,
    output mont_m, mont_done,
    input  out_valid, out_m, out_err,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/mont_op_sequencer_cond_sub.sv
// mont_cond_sub
// Conditional subtract: brings an operand one modulus step towards [0, P).
//   i_x        : operand
//   i_p        : modulus
//   o_x        : i_x - i_p when i_x >= i_p, else i_x
//   o_still_ge : reduced value is still >= i_p (operand was >= 2P)
module mont_cond_sub #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_x,
  output logic             o_still_ge
);

  logic w_ge;

  // The subtraction is only selected when i_x >= i_p, so it never wraps.
  assign w_ge       = (i_x >= i_p);
  assign o_x        = w_ge ? (i_x - i_p) : i_x;
  assign o_still_ge = (o_x >= i_p);

endmodule

// File: rtl/mont_op_sequencer.sv
// mont_op_sequencer
// Issue stage in front of the two-pass Montgomery multiplier. Accepts an
// (A, B, P) triple, rejects even/zero P and operands >= 2P, reduces A and B
// into [0, P), holds mont_start high until mont_done, then returns the
// captured product with an error code on the downstream handshake.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, aborts any operation
//   io_seq : mont_op_sequencer_if.slave (upstream, multiplier, downstream, busy)
// Optional feature macro MONT_SEQ_TIMEOUT_EN: adds a WAIT watchdog that gives
// up after TIMEOUT_CYCLES cycles and reports code 11. Without it WAIT waits
// for mont_done indefinitely.
module mont_op_sequencer
  import mont_seq_pkg::*;
#(
  parameter int WIDTH          = MONT_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  mont_op_sequencer_if.slave  io_seq
);

  state_e           r_state;
  state_e           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_mont_a;
  logic [WIDTH-1:0] r_mont_b;
  logic [WIDTH-1:0] r_mont_p;
  logic [WIDTH-1:0] r_out_m;
  err_e             r_out_err;

  logic [WIDTH-1:0] w_red_a;
  logic [WIDTH-1:0] w_red_b;
  logic             w_a_ge;
  logic             w_b_ge;

  logic             w_accept;
  logic             w_load_mont;
  logic             w_result_load;
  err_e             w_result_err;
  logic [WIDTH-1:0] w_result_m;
  logic             w_timeout;

  mont_cond_sub #(.WIDTH(WIDTH)) u_sub_a (
    .i_x        (r_a),
    .i_p        (r_p),
    .o_x        (w_red_a),
    .o_still_ge (w_a_ge)
  );

  mont_cond_sub #(.WIDTH(WIDTH)) u_sub_b (
    .i_x        (r_b),
    .i_p        (r_p),
    .o_x        (w_red_b),
    .o_still_ge (w_b_ge)
  );

`ifdef MONT_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Watchdog: cleared while launching, counts each WAIT cycle. It reads
  // TIMEOUT_CYCLES-1 on the TIMEOUT_CYCLES-th WAIT cycle, which is when we
  // give up unless mont_done shows up in that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == WAIT) &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register; reset drops any in-flight operation without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath strobes. Error checks in REDUCE are ordered so
  // an even/zero modulus is reported before any range problem, and in WAIT
  // a done arriving on the timeout cycle still wins.
  always_comb begin
    w_next_state  = r_state;
    w_accept      = 1'b0;
    w_load_mont   = 1'b0;
    w_result_load = 1'b0;
    w_result_err  = ERR_OK;
    w_result_m    = '0;
    case (r_state)
      IDLE: begin
        if (io_seq.in_valid) begin
          w_accept     = 1'b1;
          w_next_state = REDUCE;
        end
      end
      REDUCE: begin
        if (!r_p[0]) begin
          w_result_load = 1'b1;
          w_result_err  = ERR_P_EVEN;
          w_next_state  = RESP;
        end else if (w_a_ge || w_b_ge) begin
          w_result_load = 1'b1;
          w_result_err  = ERR_RANGE;
          w_next_state  = RESP;
        end else begin
          w_load_mont  = 1'b1;
          w_next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        w_next_state = WAIT;
      end
      WAIT: begin
        if (io_seq.mont_done) begin
          w_result_load = 1'b1;
          w_result_err  = ERR_OK;
          w_result_m    = io_seq.mont_m;
          w_next_state  = RESP;
        end else if (w_timeout) begin
          w_result_load = 1'b1;
          w_result_err  = ERR_TIMEOUT;
          w_next_state  = RESP;
        end
      end
      RESP: begin
        if (io_seq.out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Operand, multiplier-side and result registers. The result registers are
  // only written on the way into RESP so they stay stable while out_ready
  // is held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_p       <= '0;
      r_mont_a  <= '0;
      r_mont_b  <= '0;
      r_mont_p  <= '0;
      r_out_m   <= '0;
      r_out_err <= ERR_OK;
    end else begin
      if (w_accept) begin
        r_a <= io_seq.in_a;
        r_b <= io_seq.in_b;
        r_p <= io_seq.in_p;
      end
      if (w_load_mont) begin
        r_mont_a <= w_red_a;
        r_mont_b <= w_red_b;
        r_mont_p <= r_p;
      end
      if (w_result_load) begin
        r_out_m   <= w_result_m;
        r_out_err <= w_result_err;
      end
    end
  end

  assign io_seq.in_ready   = (r_state == IDLE);
  assign io_seq.busy       = (r_state != IDLE);
  assign io_seq.mont_start = (r_state == LAUNCH) || (r_state == WAIT);
  assign io_seq.mont_a     = r_mont_a;
  assign io_seq.mont_b     = r_mont_b;
  assign io_seq.mont_p     = r_mont_p;
  assign io_seq.out_valid  = (r_state == RESP);
  assign io_seq.out_m      = r_out_m;
  assign io_seq.out_err    = r_out_err;

endmodule

// File: tb/tb_mont_op_sequencer.sv
// tb_mont_op_sequencer
// Directed bench for mont_op_sequencer with a mock multiplier that raises
// mont_done N cycles after mont_start rises (or never). Cycle numbering for
// latency: the cycle in which the triple is accepted is cycle 1.
// Build with MONT_SEQ_TIMEOUT_EN defined to exercise the watchdog.
module tb_mont_op_sequencer;
  import mont_seq_pkg::*;

  localparam int W  = 256;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mont_op_sequencer_if #(.WIDTH(W)) seqIf ();

  mont_op_sequencer #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_seq (seqIf)
  );

  always #5 clk = ~clk;

  // Mock multiplier: counts cycles with mont_start high.
  int         mockN     = 0;
  logic       mockNever = 1'b0;
  logic       forceDone = 1'b0;
  logic [W-1:0] mockM   = '0;
  int         mockCnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mockCnt <= 0;
    end else if (seqIf.mont_start) begin
      mockCnt <= mockCnt + 1;
    end else begin
      mockCnt <= 0;
    end
  end

  assign seqIf.mont_done = forceDone |
                           (seqIf.mont_start && !mockNever && (mockCnt == mockN));
  assign seqIf.mont_m    = mockM;

  int           passCount  = 0;
  int           checkCount = 0;
  int           latency;
  int           ovSeen;
  logic         sawStart;
  logic         timedOut;
  logic [W-1:0] monA;
  logic [W-1:0] monB;
  logic [W-1:0] monP;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p);
    seqIf.in_a     = a;
    seqIf.in_b     = b;
    seqIf.in_p     = p;
    seqIf.in_valid = 1'b1;
    step();
    seqIf.in_valid = 1'b0;
  endtask

  // Issues one triple and waits (bounded) for out_valid, recording latency
  // and what the multiplier side showed when mont_start first rose.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] p, input int n,
                               input logic never, input logic [W-1:0] m);
    mockN     = n;
    mockNever = never;
    mockM     = m;
    startOp(a, b, p);
    latency  = 2;
    sawStart = 1'b0;
    timedOut = 1'b0;
    monA     = '0;
    monB     = '0;
    monP     = '0;
    while (!seqIf.out_valid && !timedOut) begin
      if (seqIf.mont_start && !sawStart) begin
        sawStart = 1'b1;
        monA     = seqIf.mont_a;
        monB     = seqIf.mont_b;
        monP     = seqIf.mont_p;
      end
      step();
      latency++;
      if (latency > 200) timedOut = 1'b1;
    end
    checkOutput("resp_bound", W'(timedOut), '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation watchdog");
  end

  initial begin
    seqIf.in_valid  = 1'b0;
    seqIf.in_a      = '0;
    seqIf.in_b      = '0;
    seqIf.in_p      = '0;
    seqIf.out_ready = 1'b1;

    // Reset state
    step();
    step();
    checkOutput("rst_in_ready",   W'(seqIf.in_ready),   W'(1));
    checkOutput("rst_busy",       W'(seqIf.busy),       '0);
    checkOutput("rst_mont_start", W'(seqIf.mont_start), '0);
    checkOutput("rst_mont_a",     seqIf.mont_a,         '0);
    checkOutput("rst_mont_b",     seqIf.mont_b,         '0);
    checkOutput("rst_mont_p",     seqIf.mont_p,         '0);
    checkOutput("rst_out_valid",  W'(seqIf.out_valid),  '0);
    checkOutput("rst_out_m",      seqIf.out_m,          '0);
    checkOutput("rst_out_err",    W'(seqIf.out_err),    '0);
    rst = 1'b0;
    step();

    // P=13, A=20 -> 7, B=7, product 5 after 10 cycles: 4+10 = cycle 14
    applyStimulus(W'(20), W'(7), W'(13), 10, 1'b0, W'('h5));
    checkOutput("ok_started",  W'(sawStart),       W'(1));
    checkOutput("ok_mont_a",   monA,               W'(7));
    checkOutput("ok_mont_b",   monB,               W'(7));
    checkOutput("ok_mont_p",   monP,               W'(13));
    checkOutput("ok_latency",  W'(latency),        W'(14));
    checkOutput("ok_out_m",    seqIf.out_m,        W'('h5));
    checkOutput("ok_out_err",  W'(seqIf.out_err),  W'(2'b00));
    checkOutput("ok_in_ready", W'(seqIf.in_ready), '0);
    step();
    checkOutput("ok_idle_ready", W'(seqIf.in_ready),  W'(1));
    checkOutput("ok_idle_valid", W'(seqIf.out_valid), '0);

    // Boundary: A==P reduces to 0, B=25 reduces to 12, done after 1 cycle
    applyStimulus(W'(13), W'(25), W'(13), 1, 1'b0, W'('h9));
    checkOutput("edge_mont_a",  monA,              '0);
    checkOutput("edge_mont_b",  monB,              W'(12));
    checkOutput("edge_latency", W'(latency),       W'(5));
    checkOutput("edge_out_m",   seqIf.out_m,       W'('h9));
    checkOutput("edge_out_err", W'(seqIf.out_err), W'(2'b00));
    step();

    // Even modulus
    applyStimulus(W'(1), W'(1), W'(12), 3, 1'b0, W'('hEE));
    checkOutput("even_started", W'(sawStart),       '0);
    checkOutput("even_latency", W'(latency),        W'(3));
    checkOutput("even_out_m",   seqIf.out_m,        '0);
    checkOutput("even_out_err", W'(seqIf.out_err),  W'(2'b01));
    step();

    // Zero modulus is also even
    applyStimulus(W'(0), W'(0), W'(0), 3, 1'b0, W'('hEE));
    checkOutput("zero_out_err", W'(seqIf.out_err), W'(2'b01));
    step();

    // A=30 >= 2*13
    applyStimulus(W'(30), W'(1), W'(13), 3, 1'b0, W'('hEE));
    checkOutput("rangeA_started", W'(sawStart),      '0);
    checkOutput("rangeA_out_m",   seqIf.out_m,       '0);
    checkOutput("rangeA_out_err", W'(seqIf.out_err), W'(2'b10));
    step();

    // B=26 == 2P: one subtract leaves exactly P
    applyStimulus(W'(5), W'(26), W'(13), 3, 1'b0, W'('hEE));
    checkOutput("rangeB_started", W'(sawStart),      '0);
    checkOutput("rangeB_out_err", W'(seqIf.out_err), W'(2'b10));
    step();

    // Downstream stall: result held, new triple ignored while busy
    seqIf.out_ready = 1'b0;
    applyStimulus(W'(2), W'(3), W'(13), 2, 1'b0, W'('hAB));
    seqIf.in_a     = W'(1);
    seqIf.in_b     = W'(1);
    seqIf.in_p     = W'(12);
    seqIf.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid",    W'(seqIf.out_valid), W'(1));
      checkOutput("hold_out_m",    seqIf.out_m,         W'('hAB));
      checkOutput("hold_out_err",  W'(seqIf.out_err),   W'(2'b00));
      checkOutput("hold_in_ready", W'(seqIf.in_ready),  '0);
      step();
    end
    seqIf.in_valid  = 1'b0;
    seqIf.out_ready = 1'b1;
    step();
    checkOutput("hold_done_valid", W'(seqIf.out_valid), '0);
    checkOutput("hold_done_ready", W'(seqIf.in_ready),  W'(1));
    checkOutput("hold_done_busy",  W'(seqIf.busy),      '0);

    // Reset while waiting on the multiplier
    mockNever = 1'b1;
    startOp(W'(1), W'(2), W'(13));
    step();
    step();
    step();
    checkOutput("abort_pre_start", W'(seqIf.mont_start), W'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_start", W'(seqIf.mont_start), '0);
    checkOutput("abort_ready", W'(seqIf.in_ready),   W'(1));
    checkOutput("abort_busy",  W'(seqIf.busy),       '0);
    checkOutput("abort_mont_a", seqIf.mont_a,        '0);
    forceDone = 1'b1;
    ovSeen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (seqIf.out_valid) ovSeen++;
    end
    forceDone = 1'b0;
    checkOutput("abort_no_valid", W'(ovSeen), '0);
    step();

`ifdef MONT_SEQ_TIMEOUT_EN
    // Multiplier never answers: give up after 16 WAIT cycles
    applyStimulus(W'(1), W'(2), W'(13), 0, 1'b1, W'('h55));
    checkOutput("to_latency", W'(latency),          W'(20));
    checkOutput("to_out_err", W'(seqIf.out_err),    W'(2'b11));
    checkOutput("to_out_m",   seqIf.out_m,          '0);
    checkOutput("to_start",   W'(seqIf.mont_start), '0);
    step();

    // Done on the 16th WAIT cycle beats the watchdog
    applyStimulus(W'(1), W'(2), W'(13), 16, 1'b0, W'('h77));
    checkOutput("race_latency", W'(latency),       W'(20));
    checkOutput("race_out_err", W'(seqIf.out_err), W'(2'b00));
    checkOutput("race_out_m",   seqIf.out_m,       W'('h77));
    step();
`else
    // No watchdog: WAIT persists until mont_done
    mockNever = 1'b1;
    startOp(W'(1), W'(2), W'(13));
    for (int i = 0; i < 40; i++) step();
    checkOutput("nto_valid", W'(seqIf.out_valid),  '0);
    checkOutput("nto_start", W'(seqIf.mont_start), W'(1));
    checkOutput("nto_busy",  W'(seqIf.busy),       W'(1));
    mockM     = W'('h3C);
    forceDone = 1'b1;
    step();
    forceDone = 1'b0;
    checkOutput("nto_resp_valid", W'(seqIf.out_valid), W'(1));
    checkOutput("nto_resp_err",   W'(seqIf.out_err),   W'(2'b00));
    checkOutput("nto_resp_m",     seqIf.out_m,         W'('h3C));
    step();
    checkOutput("nto_idle", W'(seqIf.in_ready), W'(1));
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
